// File: rtl/irq_ctl_pkg.sv
// Shared constants and helpers for the interrupt controller.
// IRQ_CTL_NMI_EN routes source 7 to NMI as a fixed edge-triggered source.
package irq_ctl_pkg;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_ENA  = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_VEC  = 2'd3;

    localparam logic [7:0] VEC_NONE = 8'h80;

`ifdef IRQ_CTL_NMI_EN
    localparam logic [7:0] IRQ_MASK   = 8'h7F;
    localparam logic [7:0] EDGE_FORCE = 8'h80;
`else
    localparam logic [7:0] IRQ_MASK   = 8'hFF;
    localparam logic [7:0] EDGE_FORCE = 8'h00;
`endif

    // Lowest active index wins; VEC_NONE when nothing is active.
    function automatic logic [7:0] vec_encode(input logic [7:0] act);
        logic [7:0] v;
        v = VEC_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) v = 8'(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/irq_ctl_if.sv
// CPU-side register bus of the interrupt controller.
interface irq_ctl_if;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic        RDY;
    logic        hit;
    logic [7:0]  rd_data;

    modport master (output AD, output DO, output WE, output RDY, input hit, input rd_data);
    modport slave  (input AD, input DO, input WE, input RDY, output hit, output rd_data);
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic ff1_q, ff2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;
endmodule

// File: rtl/irq_ctl.sv
// 8-source interrupt controller with a 4-byte register window at BASE.
// Define IRQ_CTL_NMI_EN to dedicate source 7 to NMI (forced edge mode).
module irq_ctl
    import irq_ctl_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hFE00
) (
    input  logic       clk,
    input  logic       RST,
    irq_ctl_if.slave   bus,
    input  logic [7:0] src,
    output logic       IRQ,
    output logic       NMI
);
    logic [7:0] s, sp_q;
    logic [7:0] pend_q, pend_d, ena_q, ena_d, edge_q, edge_d, edge_eff;
    logic [7:0] set, clr, rd_mux, rd_q;
    logic       wr, rd, irq_q;
    logic [1:0] off;

    for (genvar i = 0; i < 8; i++) begin : g_sync
        sync2 u_sync (
            .clk (clk),
            .rst (RST),
            .d   (src[i]),
            .q   (s[i])
        );
    end

    assign bus.hit  = (bus.AD[15:2] == BASE[15:2]);
    assign off      = bus.AD[1:0];
    assign wr       = bus.RDY & bus.WE & bus.hit;
    assign rd       = bus.RDY & ~bus.WE & bus.hit;
    assign edge_eff = edge_q | EDGE_FORCE;
    assign set      = (edge_eff & s & ~sp_q) | (~edge_eff & s);

    always_comb begin
        clr    = 8'h00;
        ena_d  = ena_q;
        edge_d = edge_q;
        if (wr) begin
            unique case (off)
                REG_PEND: clr    = bus.DO;
                REG_ENA:  ena_d  = bus.DO;
                REG_EDGE: edge_d = bus.DO & ~EDGE_FORCE;
                default:  ;
            endcase
        end
        // A simultaneous set beats the write-1-clear.
        pend_d = (pend_q & ~clr) | set;
    end

    always_comb begin
        rd_mux = VEC_NONE;
        unique case (off)
            REG_PEND: rd_mux = pend_q;
            REG_ENA:  rd_mux = ena_q;
            REG_EDGE: rd_mux = edge_eff;
            REG_VEC:  rd_mux = vec_encode(pend_q & ena_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            sp_q   <= 8'h00;
            pend_q <= 8'h00;
            ena_q  <= 8'h00;
            edge_q <= 8'h00;
            rd_q   <= 8'h00;
            irq_q  <= 1'b0;
        end else begin
            sp_q   <= s;
            pend_q <= pend_d;
            ena_q  <= ena_d;
            edge_q <= edge_d;
            if (rd) rd_q <= rd_mux;
            irq_q  <= |(pend_q & ena_q & IRQ_MASK);
        end
    end

    assign bus.rd_data = rd_q;
    assign IRQ         = irq_q;

`ifdef IRQ_CTL_NMI_EN
    logic nmi_q;

    always_ff @(posedge clk) begin
        if (RST) nmi_q <= 1'b0;
        else     nmi_q <= pend_q[7];
    end

    assign NMI = nmi_q;
`else
    assign NMI = 1'b0;
`endif
endmodule

// File: tb/tb_irq_ctl.sv
// Directed self-checking bench for irq_ctl.
module tb_irq_ctl;
    localparam logic [15:0] BASE = 16'hFE00;
`ifdef IRQ_CTL_NMI_EN
    localparam logic [7:0] EDGE_RD0 = 8'h80;
`else
    localparam logic [7:0] EDGE_RD0 = 8'h00;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic       irq;
    logic       nmi;
    int         checks = 0;
    int         errors = 0;

    irq_ctl_if bus ();

    irq_ctl #(.BASE(BASE)) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus),
        .src (src),
        .IRQ (irq),
        .NMI (nmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] data);
        bus.AD  = BASE | {14'b0, off};
        bus.DO  = data;
        bus.WE  = 1'b1;
        bus.RDY = 1'b1;
        tick(1);
        bus.WE  = 1'b0;
        bus.AD  = 16'h0000;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] off, input logic [7:0] exp);
        bus.AD  = BASE | {14'b0, off};
        bus.WE  = 1'b0;
        bus.RDY = 1'b1;
        tick(1);
        bus.AD  = 16'h0000;
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; src = 8'h00;
        bus.AD = 16'h0000; bus.DO = 8'h00; bus.WE = 1'b0; bus.RDY = 1'b1;
        tick(2);
        rst = 1'b0;

        // Reset state and address decode
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_nmi", {7'b0, nmi}, 8'h00);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("hit_out", {7'b0, bus.hit}, 8'h00);
        bus.AD = 16'hFE03; #1;
        check("hit_vec", {7'b0, bus.hit}, 8'h01);
        bus.AD = 16'hFE04; #1;
        check("hit_above", {7'b0, bus.hit}, 8'h00);
        bus.AD = 16'h0000;
        rd_check("rst_pend", 2'd0, 8'h00);
        rd_check("rst_ena", 2'd1, 8'h00);
        rd_check("rst_edge", 2'd2, EDGE_RD0);
        rd_check("rst_vec", 2'd3, 8'h80);

        // Enable and edge on source 2
        bus_write(2'd1, 8'h04);
        bus_write(2'd2, 8'h04);
        src = 8'h04;
        tick(3);
        check("edge_irq_3clk", {7'b0, irq}, 8'h00);
        src = 8'h00;
        tick(1);
        check("edge_irq_4clk", {7'b0, irq}, 8'h01);
        rd_check("edge_vec", 2'd3, 8'h02);
        bus_write(2'd0, 8'h04);
        check("clr_irq_same", {7'b0, irq}, 8'h01);
        tick(1);
        check("clr_irq_next", {7'b0, irq}, 8'h00);

        // Write outside the window is ignored
        bus.AD = 16'hFE05; bus.DO = 8'hFF; bus.WE = 1'b1;
        #1;
        check("oow_hit", {7'b0, bus.hit}, 8'h00);
        tick(1);
        bus.WE = 1'b0; bus.AD = 16'h0000;
        rd_check("oow_ena", 2'd1, 8'h04);

        // Priority encoding
        bus_write(2'd1, 8'hFF);
        bus_write(2'd2, 8'hFF);
        src = 8'h22;
        tick(4);
        src = 8'h00;
        rd_check("prio_vec1", 2'd3, 8'h01);
        bus_write(2'd0, 8'h02);
        rd_check("prio_vec5", 2'd3, 8'h05);
        bus_write(2'd0, 8'h20);
        rd_check("prio_none", 2'd3, 8'h80);
        check("prio_irq", {7'b0, irq}, 8'h00);

        // Level mode: clear has no lasting effect while source is high
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'h01);
        src = 8'h01;
        tick(4);
        bus_write(2'd0, 8'h01);
        rd_check("lvl_pend_held", 2'd0, 8'h01);
        check("lvl_irq_held", {7'b0, irq}, 8'h01);
        src = 8'h00;
        tick(2);
        bus_write(2'd0, 8'h01);
        rd_check("lvl_pend_clr", 2'd0, 8'h00);
        check("lvl_irq_clr", {7'b0, irq}, 8'h00);

        // Stall: RDY=0 freezes rd_data and blocks writes
        bus_write(2'd1, 8'h3C);
        rd_check("stall_pre", 2'd2, EDGE_RD0);
        bus.AD = BASE | 16'h0001; bus.WE = 1'b0; bus.RDY = 1'b0;
        tick(2);
        check("stall_hold", bus.rd_data, EDGE_RD0);
        bus.RDY = 1'b1;
        tick(1);
        check("stall_release", bus.rd_data, 8'h3C);
        bus.WE = 1'b1; bus.DO = 8'hFF; bus.RDY = 1'b0;
        tick(1);
        bus.WE = 1'b0; bus.RDY = 1'b1; bus.AD = 16'h0000;
        rd_check("stall_nowrite", 2'd1, 8'h3C);

        // Set and clear colliding on the same edge
        bus_write(2'd2, 8'h08);
        src = 8'h08;
        tick(2);
        bus_write(2'd0, 8'h08);
        rd_check("collide_set_wins", 2'd0, 8'h08);
        bus_write(2'd0, 8'h08);
        rd_check("collide_then_clr", 2'd0, 8'h00);
        src = 8'h00;

        // Reset mid-operation overrides a simultaneous write
        bus_write(2'd2, 8'h00);
        bus_write(2'd1, 8'hFF);
        rd_check("pre_rst_ena", 2'd1, 8'hFF);
        src = 8'hFF;
        tick(5);
        check("pre_rst_irq", {7'b0, irq}, 8'h01);
        rst = 1'b1; src = 8'h00;
        bus.AD = BASE | 16'h0001; bus.DO = 8'hFF; bus.WE = 1'b1;
        tick(1);
        rst = 1'b0; bus.WE = 1'b0; bus.AD = 16'h0000;
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        check("mid_rst_nmi", {7'b0, nmi}, 8'h00);
        check("mid_rst_rd", bus.rd_data, 8'h00);
        rd_check("mid_rst_pend", 2'd0, 8'h00);
        rd_check("mid_rst_ena", 2'd1, 8'h00);
        rd_check("mid_rst_edge", 2'd2, EDGE_RD0);

        // Source high at reset release, masked until enabled
        rst = 1'b1; src = 8'h10;
        tick(1);
        rst = 1'b0;
        tick(4);
        rd_check("rel_pend", 2'd0, 8'h10);
        check("rel_irq_masked", {7'b0, irq}, 8'h00);
        bus_write(2'd1, 8'h10);
        check("late_ena_same", {7'b0, irq}, 8'h00);
        tick(1);
        check("late_ena_irq", {7'b0, irq}, 8'h01);

        // Source 7 behaviour
        rst = 1'b1; src = 8'h00;
        tick(1);
        rst = 1'b0;
        src = 8'h80;
        tick(4);
`ifdef IRQ_CTL_NMI_EN
        check("nmi_rise", {7'b0, nmi}, 8'h01);
        check("nmi_no_irq", {7'b0, irq}, 8'h00);
        bus_write(2'd2, 8'h00);
        rd_check("nmi_edge_forced", 2'd2, 8'h80);
        bus_write(2'd0, 8'h80);
        check("nmi_clr_same", {7'b0, nmi}, 8'h01);
        tick(1);
        check("nmi_clr_next", {7'b0, nmi}, 8'h00);
`else
        check("src7_nmi_tied", {7'b0, nmi}, 8'h00);
        check("src7_irq_masked", {7'b0, irq}, 8'h00);
        bus_write(2'd2, 8'h00);
        rd_check("src7_edge_rw", 2'd2, 8'h00);
        bus_write(2'd1, 8'h80);
        tick(1);
        check("src7_irq", {7'b0, irq}, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
